fp_integrated: RTL and testbench
================================

// Module: fp_integrated
// PURPOSE
//  IEEE-754 single-precision multiplier wrapped with registered operand and result stages.
//  Operand registers A and B feed a combinational FP multiplier.
//  The multiplier drives a result register holding the product and three status flags.
//  Each register has its own write-enable, read-enable and reset.
//  The host sequences load -> compute -> capture -> read.
// PARAMETERS
//  none (fixed 32-bit binary32 format)
// PORTS
//  clk             in   1   system clock, rising-edge active
//  resetA          in   1   sync active-high reset, operand register A
//  resetB          in   1   sync active-high reset, operand register B
//  resetOut        in   1   sync active-high reset, result register (product + flags)
//  a               in   32  operand A, binary32
//  b               in   32  operand B, binary32
//  writeEnableA    in   1   capture a into register A
//  writeEnableB    in   1   capture b into register B
//  writeEnableOut  in   1   capture multiplier result and flags into result register
//  readEnableA     in   1   present register A to multiplier (else 0)
//  readEnableB     in   1   present register B to multiplier (else 0)
//  readEnableOut   in   1   present result register on outputs (else 0)
//  product         out  32  binary32 product
//  overflow        out  1   finite operands, result exponent overflowed
//  infinity        out  1   result is infinity due to an infinite operand
//  NAN             out  1   result is NaN
// BEHAVIOUR
//  Interface:
//  - One clock (clk).
//  - Reset is synchronous and active-high (resetA/resetB/resetOut).
//  Registers (each, every rising clk edge):
//  - reset has priority: value cleared to 0.
//  - Otherwise, if writeEnable=1, load D.
//  - Otherwise, hold.
//  - Reset and writeEnable together: reset wins.
//  Read gating is combinational:
//  - Register output = readEnable ? stored : 0.
//  - Outputs product/overflow/infinity/NAN are all 0 whenever readEnableOut=0 or after resetOut.
//  Latency:
//  - a,b written at edge N.
//  - readEnableA/B high during cycle N..N+1.
//  - writeEnableOut at edge N+1 captures the result.
//  - Result visible as soon as readEnableOut=1.
//  - Minimum 2 edges from operand load to valid product.
//  Multiplier (combinational), priority order:
//  1. NaN:
//     - Either operand NaN (exp=255, frac!=0), or 0 x inf.
//     - product=0x7FC00000, NAN=1.
//  2. Infinity:
//     - Either operand inf (other non-zero, non-NaN).
//     - product = {signA^signB, 8'hFF, 23'h0}, infinity=1.
//  3. Zero:
//     - Either operand zero or denormal (denormals flushed to zero).
//     - product = {sign, 31'h0}, all flags 0.
//  4. Normal path:
//     - sign = signA ^ signB.
//     - mant = {1,fracA} x {1,fracB} (48-bit).
//     - exp = expA + expB - 127.
//     - If mant[47]=1: shift right 1, exp += 1.
//     - Fraction = next 23 bits, truncated (round toward zero).
//  5. Overflow:
//     - Normal path with biased exp >= 255.
//     - product = {sign, 8'hFF, 23'h0}, overflow=1, infinity=0.
//  6. Underflow:
//     - Normal path with biased exp <= 0.
//     - product = {sign, 31'h0} (flush to zero), no flag.
//  - Flags are mutually exclusive.
//  - Exponent arithmetic uses >= 10-bit signed width to avoid wrap.
// TESTING
//  - Initial state (all enables 0, a=b=0; sequence through write/read/capture/read):
//    product=0, flags=0.
//  - a=0x42348000 (45.125), b=0x3F800000 (1.0), full sequence:
//    product=0x42348000, flags=0.
//  - a=0x40000000, b=0x40400000 (2 x 3):
//    product=0x40C00000.
//  - a=b=0x7F000000:
//    product=0x7F800000, overflow=1.
//  - a=0x7F800000, b=0:
//    product=0x7FC00000, NAN=1.
//  - a=0xFF800000, b=0x40000000:
//    product=0xFF800000, infinity=1.
//  - resetOut with writeEnableOut in the same cycle:
//    product=0.
//  - readEnableOut=0:
//    outputs 0 regardless of the stored result.

Source files
------------

// File: rtl/fp_integrated.sv
// Binary32 multiplier between registered operands A/B and a registered result with status flags.
// Each register has a sync reset, a write enable and a combinational read gate.

module fp_reg #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         we,
  input  logic         re,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  logic [W-1:0] stored;

  always_ff @(posedge clk) begin
    if (rst)     stored <= '0;
    else if (we) stored <= d;
  end

  assign q = re ? stored : '0;
endmodule

module fp_integrated (
  input  logic        clk,
  input  logic        resetA,
  input  logic        resetB,
  input  logic        resetOut,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        writeEnableA,
  input  logic        writeEnableB,
  input  logic        writeEnableOut,
  input  logic        readEnableA,
  input  logic        readEnableB,
  input  logic        readEnableOut,
  output logic [31:0] product,
  output logic        overflow,
  output logic        infinity,
  output logic        NAN
);
  logic [31:0] opa, opb;
  logic [34:0] res_d, res_q;

  fp_reg #(.W(32)) u_rega (
    .clk(clk), .rst(resetA), .we(writeEnableA), .re(readEnableA), .d(a), .q(opa)
  );
  fp_reg #(.W(32)) u_regb (
    .clk(clk), .rst(resetB), .we(writeEnableB), .re(readEnableB), .d(b), .q(opb)
  );

  logic        sa, sb, sp;
  logic [7:0]  ea, eb;
  logic [22:0] fa, fb, fp;
  logic        a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
  logic [47:0] mant;
  logic signed [9:0] ep;

  assign {sa, ea, fa} = opa;
  assign {sb, eb, fb} = opb;
  assign sp     = sa ^ sb;
  assign a_nan  = (ea == 8'hFF) && (fa != '0);
  assign b_nan  = (eb == 8'hFF) && (fb != '0);
  assign a_inf  = (ea == 8'hFF) && (fa == '0);
  assign b_inf  = (eb == 8'hFF) && (fb == '0);
  // Denormals have exp==0 and are flushed to zero together with true zeros
  assign a_zero = (ea == 8'h00);
  assign b_zero = (eb == 8'h00);
  assign mant   = {24'd0, 1'b1, fa} * {24'd0, 1'b1, fb};
  assign ep     = $signed({2'b00, ea}) + $signed({2'b00, eb}) - 10'sd127
                + $signed({9'd0, mant[47]});
  assign fp     = mant[47] ? mant[46:24] : mant[45:23];

  // res_d layout: {NAN, infinity, overflow, product}
  always_comb begin
    res_d = '0;
    if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero))
      res_d = {3'b100, 32'h7FC0_0000};
    else if (a_inf || b_inf)
      res_d = {3'b010, sp, 8'hFF, 23'd0};
    else if (a_zero || b_zero)
      res_d = {3'b000, sp, 31'd0};
    else if (ep >= 10'sd255)
      res_d = {3'b001, sp, 8'hFF, 23'd0};
    else if (ep <= 10'sd0)
      res_d = {3'b000, sp, 31'd0};
    else
      res_d = {3'b000, sp, ep[7:0], fp};
  end

  fp_reg #(.W(35)) u_regout (
    .clk(clk), .rst(resetOut), .we(writeEnableOut), .re(readEnableOut), .d(res_d), .q(res_q)
  );

  assign {NAN, infinity, overflow, product} = res_q;
endmodule

// File: tb/tb_fp_integrated.sv
// Directed bench for fp_integrated: load -> compute -> capture -> read sequences.
module tb_fp_integrated;
  logic        clk = 1'b0;
  logic        resetA, resetB, resetOut;
  logic [31:0] a, b;
  logic        writeEnableA, writeEnableB, writeEnableOut;
  logic        readEnableA, readEnableB, readEnableOut;
  logic [31:0] product;
  logic        overflow, infinity, NAN;
  int passed = 0;
  int total  = 0;

  fp_integrated dut (
    .clk(clk), .resetA(resetA), .resetB(resetB), .resetOut(resetOut),
    .a(a), .b(b),
    .writeEnableA(writeEnableA), .writeEnableB(writeEnableB), .writeEnableOut(writeEnableOut),
    .readEnableA(readEnableA), .readEnableB(readEnableB), .readEnableOut(readEnableOut),
    .product(product), .overflow(overflow), .infinity(infinity), .NAN(NAN)
  );

  always #5 clk = ~clk;

  // Load operands, capture the product one edge later, then enable the output.
  task automatic do_mul(input logic [31:0] x, input logic [31:0] y);
    @(negedge clk);
    a = x; b = y;
    writeEnableA = 1'b1; writeEnableB = 1'b1;
    readEnableA = 1'b1; readEnableB = 1'b1; readEnableOut = 1'b0;
    @(negedge clk);
    writeEnableA = 1'b0; writeEnableB = 1'b0; writeEnableOut = 1'b1;
    @(negedge clk);
    writeEnableOut = 1'b0; readEnableOut = 1'b1;
    #1;
  endtask

  task automatic test_reset;
    @(negedge clk);
    resetA = 1'b1; resetB = 1'b1; resetOut = 1'b1;
    a = '0; b = '0;
    writeEnableA = 1'b0; writeEnableB = 1'b0; writeEnableOut = 1'b0;
    readEnableA = 1'b0; readEnableB = 1'b0; readEnableOut = 1'b0;
    repeat (2) @(negedge clk);
    resetA = 1'b0; resetB = 1'b0; resetOut = 1'b0;
    readEnableOut = 1'b1;
    #1;
    total++;
    if ({overflow, infinity, NAN, product} !== 35'd0)
      $display("FAIL reset_state got %h exp %h", {overflow, infinity, NAN, product}, 35'd0);
    else passed++;
    do_mul(32'h0, 32'h0);
    total++;
    if (product !== 32'h0) $display("FAIL reset_seq_product got %h exp %h", product, 32'h0);
    else passed++;
    total++;
    if ({overflow, infinity, NAN} !== 3'b000)
      $display("FAIL reset_seq_flags got %b exp %b", {overflow, infinity, NAN}, 3'b000);
    else passed++;
  endtask

  task automatic test_normal;
    logic [31:0] va [5] = '{32'h42348000, 32'h40000000, 32'h3FFFFFFF, 32'h80000000, 32'h3FC00000};
    logic [31:0] vb [5] = '{32'h3F800000, 32'h40400000, 32'h3FFFFFFF, 32'h40A00000, 32'hBFC00000};
    logic [31:0] ve [5] = '{32'h42348000, 32'h40C00000, 32'h407FFFFE, 32'h80000000, 32'hC0100000};
    for (int i = 0; i < 5; i++) begin
      do_mul(va[i], vb[i]);
      total++;
      if (product !== ve[i])
        $display("FAIL normal_product[%0d] got %h exp %h", i, product, ve[i]);
      else passed++;
      total++;
      if ({overflow, infinity, NAN} !== 3'b000)
        $display("FAIL normal_flags[%0d] got %b exp %b", i, {overflow, infinity, NAN}, 3'b000);
      else passed++;
    end
  endtask

  task automatic test_special;
    // flags order {overflow, infinity, NAN}
    logic [31:0] va [6] = '{32'h7F000000, 32'h7F800000, 32'hFF800000, 32'h7FC00001, 32'h00800000, 32'hFF000000};
    logic [31:0] vb [6] = '{32'h7F000000, 32'h00000000, 32'h40000000, 32'h3F800000, 32'h00800000, 32'h7F000000};
    logic [31:0] ve [6] = '{32'h7F800000, 32'h7FC00000, 32'hFF800000, 32'h7FC00000, 32'h00000000, 32'hFF800000};
    logic [2:0]  vf [6] = '{3'b100, 3'b001, 3'b010, 3'b001, 3'b000, 3'b100};
    for (int i = 0; i < 6; i++) begin
      do_mul(va[i], vb[i]);
      total++;
      if (product !== ve[i])
        $display("FAIL special_product[%0d] got %h exp %h", i, product, ve[i]);
      else passed++;
      total++;
      if ({overflow, infinity, NAN} !== vf[i])
        $display("FAIL special_flags[%0d] got %b exp %b", i, {overflow, infinity, NAN}, vf[i]);
      else passed++;
    end
  endtask

  task automatic test_reset_priority;
    do_mul(32'h40000000, 32'h40400000);
    @(negedge clk);
    resetOut = 1'b1; writeEnableOut = 1'b1;
    @(negedge clk);
    resetOut = 1'b0; writeEnableOut = 1'b0;
    #1;
    total++;
    if ({overflow, infinity, NAN, product} !== 35'd0)
      $display("FAIL reset_over_write got %h exp %h", {overflow, infinity, NAN, product}, 35'd0);
    else passed++;
  endtask

  task automatic test_read_gating;
    do_mul(32'h7F000000, 32'h7F000000);
    @(negedge clk);
    readEnableOut = 1'b0;
    #1;
    total++;
    if ({overflow, infinity, NAN, product} !== 35'd0)
      $display("FAIL read_gate_off got %h exp %h", {overflow, infinity, NAN, product}, 35'd0);
    else passed++;
    @(negedge clk);
    readEnableOut = 1'b1;
    #1;
    total++;
    if ({overflow, product} !== {1'b1, 32'h7F800000})
      $display("FAIL read_gate_on got %h exp %h", {overflow, product}, {1'b1, 32'h7F800000});
    else passed++;
  endtask

  task automatic test_operand_gating;
    // A loaded with 2.0 but gated off: multiplier sees +0 x 3.0
    @(negedge clk);
    a = 32'h40000000; b = 32'h40400000;
    writeEnableA = 1'b1; writeEnableB = 1'b1;
    readEnableA = 1'b0; readEnableB = 1'b1;
    @(negedge clk);
    writeEnableA = 1'b0; writeEnableB = 1'b0; writeEnableOut = 1'b1;
    @(negedge clk);
    writeEnableOut = 1'b0; readEnableOut = 1'b1;
    #1;
    total++;
    if (product !== 32'h0) $display("FAIL operand_gate got %h exp %h", product, 32'h0);
    else passed++;
    // resetB clears operand B: 2.0 x 0 -> +0
    @(negedge clk);
    readEnableA = 1'b1; resetB = 1'b1;
    @(negedge clk);
    resetB = 1'b0; writeEnableOut = 1'b1;
    @(negedge clk);
    writeEnableOut = 1'b0;
    #1;
    total++;
    if (product !== 32'h0) $display("FAIL operand_resetB got %h exp %h", product, 32'h0);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_normal();
    test_special();
    test_reset_priority();
    test_read_gating();
    test_operand_gating();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
